// File: rtl/mul_sched_pkg.sv
// Shared definitions for the multiplier scheduler: FSM encoding, default sizes
// and a ceiling-log2 helper used for pointer and counter widths.
package mul_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 64;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_sched_rr_arbiter.sv
// Rotating-priority search: picks the first asserted request at or after the
// pointer, wrapping from NREQ-1 back to 0. Purely combinational.
module rr_arbiter
    import mul_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [IW:0] w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_pos >= (IW+1)'(NREQ)) w_pos = w_pos - (IW+1)'(NREQ);
            if (!o_any && i_req[w_pos[IW-1:0]]) begin
                o_any                = 1'b1;
                o_gnt[w_pos[IW-1:0]] = 1'b1;
                o_idx                = w_pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one sequential multiplier datapath among NREQ
// requesters; sequences clear/load/run and returns the product with a done pulse.
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREQ    = DEF_NREQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [2*WIDTH-1:0]    result,
    output logic                  err,
    output logic                  dp_clr,
    output logic                  dp_load,
    output logic                  dp_busy,
    output logic [WIDTH-1:0]      dp_op_a,
    output logic [WIDTH-1:0]      dp_op_b,
    input  logic [2*WIDTH-1:0]    dp_mul,
    input  logic                  dp_ready
);

    localparam int IW = clog2(NREQ);
    localparam int CW = clog2(TIMEOUT);

    state_t               r_state;
    logic [IW-1:0]        r_ptr;
    logic [IW-1:0]        r_idx;
    logic [CW-1:0]        r_cnt;
    logic [NREQ-1:0]      r_gnt;
    logic [NREQ-1:0]      r_done;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_err;
    logic                 r_clr;
    logic                 r_load;
    logic                 r_busy;
    logic [WIDTH-1:0]     r_op_a;
    logic [WIDTH-1:0]     r_op_b;

    logic [NREQ-1:0]      w_gnt;
    logic [IW-1:0]        w_idx;
    logic                 w_any;
    logic [WIDTH-1:0]     w_a [NREQ];
    logic [WIDTH-1:0]     w_b [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_a[g] = op_a[g*WIDTH +: WIDTH];
        assign w_b[g] = op_b[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_clr    <= 1'b0;
            r_load   <= 1'b0;
            r_busy   <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
        end else begin
            r_clr  <= 1'b0;
            r_load <= 1'b0;
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_idx   <= w_idx;
                        r_op_a  <= w_a[w_idx];
                        r_op_b  <= w_b[w_idx];
                        r_gnt   <= w_gnt;
                        r_clr   <= 1'b1;
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_load  <= 1'b1;
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + CW'(1);
                    // dp_ready has priority, so a completion on the last allowed cycle is not an error
                    if (dp_ready || r_cnt == CW'(TIMEOUT-1)) begin
                        r_busy   <= 1'b0;
                        r_result <= dp_mul;
                        r_done   <= r_gnt;
                        r_err    <= !dp_ready;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_gnt   <= '0;
                    r_ptr   <= (r_idx == IW'(NREQ-1)) ? '0 : r_idx + IW'(1);
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign result  = r_result;
    assign err     = r_err;
    assign dp_clr  = r_clr;
    assign dp_load = r_load;
    assign dp_busy = r_busy;
    assign dp_op_a = r_op_a;
    assign dp_op_b = r_op_b;

endmodule
